add_share_arb: RTL
==================

ADD_SHARE_ARB -- requirements
Module: add_share_arb

Interface
REQ-001 SHALL have no parameters; widths are fixed (operands 32 b, result 40 b).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req0_valid / req1_valid  input  1  requester N presents an operand pair.
REQ-005 SHALL have ports: req0_a, req0_b / req1_a, req1_b  input  32  operands of requester N.
REQ-006 SHALL have ports: req0_ready / req1_ready  output  1  requester N's pair is accepted this cycle.
REQ-007 SHALL have port: prio_mode  input  1  0 = round-robin, 1 = fixed priority to requester 0.
REQ-008 SHALL have ports: res_valid  output  1; res_ready  input  1  result handshake.
REQ-009 SHALL have port: res_data  output  40  {7'b0, carry_out, sum[31:0]}.
REQ-010 SHALL have port: res_id  output  1  requester that owns res_data.
REQ-011 SHALL have port: busy  output  1  high while either pipeline stage holds a valid entry.

Function
REQ-012 SHALL implement two stages: S1 (operand register: s1_valid, a, b, id) and S2 (result register: res_valid, res_data, res_id); a single shared 32-bit ripple-carry adder (bit32_RCA, Cin = 0) sits combinationally between S1 and S2.
REQ-013 SHALL transfer a request on a cycle when reqN_valid and reqN_ready are both high; at most one requester is granted per cycle.
REQ-014 SHALL compute s2_free = !res_valid | res_ready and s1_free = !s1_valid | s2_free; reqN_ready may be high only when s1_free is high.
REQ-015 SHALL, with prio_mode = 1, grant req0 whenever req0_valid; req1 only when !req0_valid.
REQ-016 SHALL, with prio_mode = 0 and both valid, grant the requester not granted most recently; with one valid, grant it; last_grant updates only on an actual transfer.
REQ-017 SHALL drive readies combinationally from valids, prio_mode, last_grant and s1_free; readies SHALL NOT depend on operand values.
REQ-018 SHALL, on transfer, load S1 with the granted operands and id at the next edge; S1 SHALL move to S2 when s2_free, else hold unchanged.
REQ-019 SHALL give latency 2: transfer at edge k → res_valid high after edge k+2 with no backpressure; throughput 1 result/cycle when res_ready held high.
REQ-020 SHALL hold res_valid, res_data, res_id stable while res_valid & !res_ready.
REQ-021 SHALL deassert res_valid after a res_valid & res_ready edge unless S1 moves in the same edge.
REQ-022 SHALL, with S1 and S2 both full and res_ready low, drive both readies low (no entry lost or overwritten).
REQ-023 SHALL, with S1 and S2 full and res_ready high, accept a new request the same cycle (all three moves on one edge).
REQ-024 SHALL zero-extend: res_data[32] = adder carry out, res_data[39:33] = 0.
REQ-025 SHALL preserve per-requester result order (in-order pipeline, no reordering).
REQ-026 SHALL drive busy = s1_valid | res_valid.

Reset
REQ-027 SHALL, on a clk edge with RST high, clear s1_valid, res_valid, res_data, res_id, last_grant (= requester 1, so req0 wins first contention); busy = 0.
REQ-028 SHALL drive req0_ready and req1_ready low during any cycle where RST is high.
REQ-029 SHALL discard in-flight S1/S2 entries on reset mid-operation; no result for them is ever presented.

Verification
REQ-030 Single req0: a=5, b=7, res_ready=1 → res_valid two edges after transfer, res_data=40'h000000000C, res_id=0.
REQ-031 Overflow: a=32'hFFFFFFFF, b=32'h00000001 → res_data=40'h0100000000; a=b=32'hFFFFFFFF → 40'h01FFFFFFFE.
REQ-032 prio_mode=0, both valid for 4 cycles from reset → grants 0,1,0,1; res_id sequence 0,1,0,1; prio_mode=1 same stimulus → grants 0,0,0,0.
REQ-033 Backpressure: res_ready=0, issue 3 requests → first two accepted, readies low thereafter; raise res_ready → results drain in order, third accepted same cycle, no loss or duplication.
REQ-034 Reset mid-operation: two transfers in flight, assert RST for one edge → res_valid=0, busy=0, readies low during RST, no stale result after release.

Source files
------------

// File: rtl/add_share_arb.sv
// Two-requester arbiter in front of a shared two-stage 32-bit adder pipeline.
// Results carry the owner id and the adder carry-out, zero-extended to 40 bits.
module add_share_arb (
    input  logic        clk,
    input  logic        RST,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    input  logic        prio_mode,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [39:0] res_data,
    output logic        res_id,
    output logic        busy
);
    localparam int DATA_W = 32;
    localparam int RES_W  = 40;

    // Shared adder: plain ripple carry, carry-in tied to zero.
    function automatic logic [DATA_W:0] bit32_rca(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] s;
        logic              c;
        c = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, s};
    endfunction

    logic                     vld_p1;
    logic                     id_p1;
    logic signed [DATA_W-1:0] a_p1;
    logic signed [DATA_W-1:0] b_p1;
    logic                     vld_p2;
    logic                     id_p2;
    logic [RES_W-1:0]         data_p2;
    logic                     last_grant;
    logic                     s1_free;
    logic                     s2_free;
    logic                     gnt0;
    logic                     gnt1;
    logic                     xfer;
    logic [DATA_W:0]          sum_p1;

    assign s2_free = !vld_p2 | res_ready;
    assign s1_free = !vld_p1 | s2_free;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!RST && s1_free) begin
            if (prio_mode) begin
                if (req0_valid)      gnt0 = 1'b1;
                else if (req1_valid) gnt1 = 1'b1;
            end else if (req0_valid && req1_valid) begin
                // Alternate on contention: whoever did not win last time wins now.
                if (last_grant) gnt0 = 1'b1;
                else            gnt1 = 1'b1;
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign xfer       = gnt0 | gnt1;

    // Stage p1: operand register
    always_ff @(posedge clk) begin
        if (RST) begin
            vld_p1     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (s1_free) vld_p1 <= xfer;
            if (xfer)    last_grant <= gnt1;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            id_p1 <= gnt1;
            a_p1  <= gnt1 ? req1_a : req0_a;
            b_p1  <= gnt1 ? req1_b : req0_b;
        end
    end

    assign sum_p1 = bit32_rca(a_p1, b_p1);

    // Stage p2: result register
    always_ff @(posedge clk) begin
        if (RST) begin
            vld_p2  <= 1'b0;
            id_p2   <= 1'b0;
            data_p2 <= '0;
        end else if (s2_free) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                id_p2   <= id_p1;
                data_p2 <= {{(RES_W-DATA_W-1){1'b0}}, sum_p1};
            end
        end
    end

    assign res_valid = vld_p2;
    assign res_data  = data_p2;
    assign res_id    = id_p2;
    assign busy      = vld_p1 | vld_p2;
endmodule
